act_fetch_resp: RTL and testbench
=================================

Name: act_fetch_resp

Overview:
- Responder side of the activation fetch handshake.
- Accepts fetch-request pulses from the activation controller (CTRLACT_PlsFetch) and reads packed activation words from a two-bank ping-pong activation SRAM.
- Returns each word with a one-cycle CTRLACT_GetAct strobe.
- Owns the bank pointer and releases each bank back to the loader once a frame's worth of words has been read.

Parameters:
- ACT_WIDTH, 64, bits per packed activation word.
- ADDR_WIDTH, 10, word address width within one bank.
- REQ_DEPTH, 4, maximum outstanding (accepted, not yet issued) requests.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- CFG_NumWrd  in  ADDR_WIDTH  words per frame minus 1; sampled only in IDLE.
- CTRLACT_PlsFetch  in  1  fetch request; each high cycle is one request.
- CTRLACT_GetAct  out  1  one-cycle strobe: ActDat valid.
- ActDat  out  ACT_WIDTH  activation word.
- BankFull  in  2  per-bank level from loader: bank holds a complete frame.
- BankRls  out  2  one-cycle pulse per bank: bank consumed, loader may refill.
- SramRdEn  out  1  SRAM read enable.
- SramRdBank  out  1  bank select for the read.
- SramRdAddr  out  ADDR_WIDTH  word address.
- SramRdDat  in  ACT_WIDTH  SRAM read data, valid 1 cycle after SramRdEn.
- ErrOvf  out  1  sticky: request accepted while pending count was REQ_DEPTH.

Behaviour:
- Reset values:
  - All outputs 0: CTRLACT_GetAct, ActDat, BankRls, SramRdEn, SramRdBank, SramRdAddr, ErrOvf.
  - Pending counter 0, bank pointer 0, state IDLE.
- Pending counter (width clog2(REQ_DEPTH+1)):
  - +1 on PlsFetch.
  - −1 on read issue.
  - Both in the same cycle: unchanged.
  - PlsFetch at REQ_DEPTH with no issue that cycle: counter holds, ErrOvf set, request dropped.
- FSM states:
  - IDLE to WAIT when pending>0 or PlsFetch.
  - WAIT to RD when BankFull[ptr].
  - RD to IDLE when pending==1 and no PlsFetch in the issue cycle.
  - RD to WAIT when the wrap issue occurs and BankFull[~ptr]==0.
  - Otherwise RD stays in RD.
- Issue:
  - In RD, one read per cycle while pending>0.
  - SramRdEn=1; SramRdBank=ptr; SramRdAddr=address counter. These are registered outputs.
- Latency:
  - CTRLACT_GetAct and ActDat are registered from the SRAM return.
  - GetAct is high exactly 2 cycles after the SramRdEn cycle: 1 cycle SRAM latency plus 1 cycle output register.
  - Minimum PlsFetch-to-GetAct latency is 4 cycles from IDLE: accept, WAIT/RD decision, issue, SRAM, output.
  - Back-to-back requests sustain 1 word per cycle.
- Address and bank rules:
  - Address increments per issue.
  - At issue of address CFG_NumWrd, address wraps to 0 and ptr toggles.
  - BankRls[old ptr] pulses the cycle after that final read's data returns (GetAct cycle), not at issue.
- Simultaneous events:
  - BankFull dropping for the current bank mid-frame is a loader protocol error. It is ignored; the block keeps reading.
  - CFG_NumWrd==0 means 1 word per frame; every issue wraps.
- Reset mid-operation:
  - Reads in flight are discarded; no GetAct after reset.
  - BankRls is not issued for the partially read bank.
- ErrOvf clears only on reset.

Decomposition:
- Shared package: ACT_WIDTH/ADDR_WIDTH defaults, FSM state encoding (IDLE/WAIT/RD, 2 bits), clog2 macro.
- One sub-module, act_req_cnt: up/down saturating pending counter with overflow flag.
- The FSM, address and bank logic stays in the top.

Test Plan:
- Single request: CFG_NumWrd=3, BankFull=01, one PlsFetch at cycle 0 -> SramRdEn at cycle 2 (bank 0, addr 0); GetAct at cycle 4 with ActDat equal to SRAM word 0.
- Streaming and bank swap: CFG_NumWrd=3, BankFull=11, PlsFetch held high for 8 cycles:
  - 8 GetAct strobes on consecutive cycles, addresses 0-3 on bank 0 then 0-3 on bank 1.
  - BankRls=01 on the 4th GetAct cycle, BankRls=10 on the 8th.
- Bank stall: BankFull=01, CFG_NumWrd=1, 3 requests:
  - 2 words from bank 0, BankRls=01, then the FSM waits in WAIT.
  - Raise BankFull[1] 10 cycles later -> 3rd GetAct 4 cycles after the rise, from bank 1 addr 0.
- Overflow: BankFull=00, 5 PlsFetch pulses with REQ_DEPTH=4 -> ErrOvf=1 after the 5th pulse.
  - Then raise BankFull=01 -> exactly 4 GetAct strobes.
- Simultaneous inc/dec: in RD with pending=1, assert PlsFetch in the issue cycle -> pending stays 1 and the FSM stays in RD with no idle cycle.
- Reset mid-stream: assert rst_n low one cycle after SramRdEn -> no GetAct afterwards.
  - All outputs and the pointer read 0 during and after reset; no BankRls is issued.

Source files
------------

// File: rtl/act_fetch_resp_pkg.sv
// Shared definitions for the activation fetch responder: default widths,
// FSM state encoding and the pending-counter width helper.
package act_fetch_resp_pkg;

  localparam int ACT_WIDTH_DEF  = 64;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int REQ_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RD   = 2'd2
  } fetch_state_e;

  // Bits needed to count 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/act_req_cnt.sv
// Pending-request counter: up on request, down on issue, saturates at DEPTH
// and raises a sticky overflow flag when a request arrives while full.
module act_req_cnt
  import act_fetch_resp_pkg::*;
#(
  parameter int DEPTH = REQ_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_inc,
  input  logic                          i_dec,
  output logic [cnt_width(DEPTH)-1:0]   o_cnt,
  output logic                          o_ovf
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          w_full;

  assign w_full = (r_cnt == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      if (i_inc && !i_dec) begin
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CW'(1);
      end else if (i_dec && !i_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/act_fetch_resp.sv
// Activation fetch responder: turns fetch pulses into ping-pong SRAM reads,
// returns each word with a GetAct strobe and releases banks after a frame.
module act_fetch_resp
  import act_fetch_resp_pkg::*;
#(
  parameter int ACT_WIDTH  = ACT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int REQ_DEPTH  = REQ_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] CFG_NumWrd,
  input  logic                  CTRLACT_PlsFetch,
  output logic                  CTRLACT_GetAct,
  output logic [ACT_WIDTH-1:0]  ActDat,
  input  logic [1:0]            BankFull,
  output logic [1:0]            BankRls,
  output logic                  SramRdEn,
  output logic                  SramRdBank,
  output logic [ADDR_WIDTH-1:0] SramRdAddr,
  input  logic [ACT_WIDTH-1:0]  SramRdDat,
  output logic                  ErrOvf
);

  localparam int CW = cnt_width(REQ_DEPTH);

  fetch_state_e          r_state, w_state_nxt;
  logic                  r_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_num_wrd;
  logic [1:0]            r_bank_full;
  logic                  r_rd_last;
  logic                  r_dat_vld;
  logic                  r_dat_last;
  logic                  r_dat_bank;
  logic [CW-1:0]         w_pending;
  logic                  w_ovf;
  logic                  w_pend_nz;
  logic                  w_pend_one;
  logic                  w_issue;
  logic                  w_wrap;

  act_req_cnt #(.DEPTH(REQ_DEPTH)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (CTRLACT_PlsFetch),
    .i_dec (w_issue),
    .o_cnt (w_pending),
    .o_ovf (w_ovf)
  );

  assign ErrOvf     = w_ovf;
  assign w_pend_nz  = (w_pending != '0);
  assign w_pend_one = (w_pending == CW'(1));

  // The first read of a burst issues on the WAIT decision cycle itself, so the
  // registered SRAM strobe lands in the first RD cycle.
  assign w_issue = w_pend_nz &&
                   (((r_state == ST_WAIT) && r_bank_full[r_ptr]) || (r_state == ST_RD));
  assign w_wrap  = w_issue && (r_addr == r_num_wrd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path leaves w_state_nxt unassigned and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pend_nz || CTRLACT_PlsFetch) w_state_nxt = ST_WAIT;
      ST_WAIT, ST_RD: begin
        if (w_issue) begin
          if (w_pend_one && !CTRLACT_PlsFetch)       w_state_nxt = ST_IDLE;
          else if (w_wrap && !r_bank_full[~r_ptr])   w_state_nxt = ST_WAIT;
          else                                       w_state_nxt = ST_RD;
        end else if (r_state == ST_RD) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // BankFull is registered once; a loader rise reaches the FSM a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= 2'b00;
      r_num_wrd   <= '0;
    end else begin
      r_bank_full <= BankFull;
      if (r_state == ST_IDLE) r_num_wrd <= CFG_NumWrd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SramRdEn   <= 1'b0;
      SramRdBank <= 1'b0;
      SramRdAddr <= '0;
      r_addr     <= '0;
      r_ptr      <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      SramRdEn  <= w_issue;
      r_rd_last <= w_wrap;
      if (w_issue) begin
        SramRdBank <= r_ptr;
        SramRdAddr <= r_addr;
        if (w_wrap) begin
          r_addr <= '0;
          r_ptr  <= ~r_ptr;
        end else begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Release travels with the final read so it pulses on that word's GetAct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dat_vld      <= 1'b0;
      r_dat_last     <= 1'b0;
      r_dat_bank     <= 1'b0;
      CTRLACT_GetAct <= 1'b0;
      ActDat         <= '0;
      BankRls        <= 2'b00;
    end else begin
      r_dat_vld      <= SramRdEn;
      r_dat_last     <= SramRdEn && r_rd_last;
      r_dat_bank     <= SramRdBank;
      CTRLACT_GetAct <= r_dat_vld;
      if (r_dat_vld) ActDat <= SramRdDat;
      BankRls[0]     <= r_dat_vld && r_dat_last && !r_dat_bank;
      BankRls[1]     <= r_dat_vld && r_dat_last &&  r_dat_bank;
    end
  end

endmodule

// File: tb/tb_act_fetch_resp.sv
// Self-checking bench for act_fetch_resp: directed timing scenarios plus
// randomized streaming, scored against a frame/bank arithmetic model.
module tb_act_fetch_resp;
  import act_fetch_resp_pkg::*;

  localparam int DW = ACT_WIDTH_DEF;
  localparam int AW = ADDR_WIDTH_DEF;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] num_wrd = '0;
  logic          pls = 1'b0;
  logic          get_act;
  logic [DW-1:0] act_dat;
  logic [1:0]    bank_full = 2'b00;
  logic [1:0]    bank_rls;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_dat = '0;
  logic          err_ovf;

  logic [DW-1:0] mem [0:1][0:NW-1];

  int n_checks = 0;
  int n_errors = 0;
  int get_cnt  = 0;
  int unsigned rd_idx = 0;

  act_fetch_resp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .CFG_NumWrd       (num_wrd),
    .CTRLACT_PlsFetch (pls),
    .CTRLACT_GetAct   (get_act),
    .ActDat           (act_dat),
    .BankFull         (bank_full),
    .BankRls          (bank_rls),
    .SramRdEn         (rd_en),
    .SramRdBank       (rd_bank),
    .SramRdAddr       (rd_addr),
    .SramRdDat        (rd_dat),
    .ErrOvf           (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle-latency SRAM.
  always @(posedge clk) if (rd_en) rd_dat <= mem[rd_bank][rd_addr];

  // Reference: the k-th word returned since reset is word k mod frame of
  // bank (k / frame) mod 2; the last word of a frame carries that bank's release.
  always @(negedge clk) begin
    int unsigned frame, a, b;
    logic [1:0] exp_rls;
    if (!rst_n) begin
      rd_idx = 0;
    end else if (get_act) begin
      frame   = int'(num_wrd) + 1;
      a       = rd_idx % frame;
      b       = (rd_idx / frame) % 2;
      exp_rls = (a == frame - 1) ? ((b == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("mon_act_dat", act_dat, mem[b][a]);
      check("mon_bank_rls", bank_rls, exp_rls);
      rd_idx++;
      get_cnt++;
    end else if (bank_rls != 2'b00) begin
      check("mon_rls_without_get", bank_rls, 2'b00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pls = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_get"},  get_act, 0);
    check({tag, "_dat"},  act_dat, 0);
    check({tag, "_rls"},  bank_rls, 0);
    check({tag, "_en"},   rd_en, 0);
    check({tag, "_bank"}, rd_bank, 0);
    check({tag, "_addr"}, rd_addr, 0);
    check({tag, "_ovf"},  err_ovf, 0);
  endtask

  int g0, nget, first_get, last_get, rls01_c, rls10_c, nrd, nreq, rls_seen;
  int get_t [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NW; a++)
        mem[b][a] = {$urandom(), $urandom()};

    #23;
    check_all_zero("reset");

    // Single request.
    num_wrd = 3; bank_full = 2'b01;
    do_reset();
    g0 = get_cnt;
    for (int c = 0; c < 8; c++) begin
      pls = (c == 0);
      if (c == 2) begin
        check("single_rden", rd_en, 1);
        check("single_bank", rd_bank, 0);
        check("single_addr", rd_addr, 0);
      end
      if (c == 3) check("single_get_early", get_act, 0);
      if (c == 4) begin
        check("single_get", get_act, 1);
        check("single_dat", act_dat, mem[0][0]);
      end
      tick();
    end
    check("single_count", get_cnt - g0, 1);

    // Streaming with bank swap.
    num_wrd = 3; bank_full = 2'b11;
    do_reset();
    nget = 0; first_get = -1; last_get = -1; rls01_c = -1; rls10_c = -1; nrd = 0;
    for (int c = 0; c < 16; c++) begin
      pls = (c < 8);
      if (get_act) begin
        nget++;
        if (first_get < 0) first_get = c;
        last_get = c;
      end
      if (bank_rls == 2'b01) rls01_c = c;
      if (bank_rls == 2'b10) rls10_c = c;
      if (rd_en) begin
        check("stream_addr", rd_addr, nrd % 4);
        check("stream_bank", rd_bank, nrd / 4);
        nrd++;
      end
      tick();
    end
    check("stream_nget", nget, 8);
    check("stream_first", first_get, 4);
    check("stream_last", last_get, 11);
    check("stream_rls01", rls01_c, 7);
    check("stream_rls10", rls10_c, 11);

    // Bank stall: bank 1 arrives at cycle 13.
    num_wrd = 1; bank_full = 2'b01;
    do_reset();
    nget = 0;
    for (int c = 0; c < 25; c++) begin
      pls = (c < 3);
      if (c == 13) bank_full = 2'b11;
      if (get_act) begin
        if (nget < 8) get_t[nget] = c;
        nget++;
        if (nget == 3) check("stall_dat", act_dat, mem[1][0]);
      end
      if (c == 15) begin
        check("stall_rden", rd_en, 1);
        check("stall_bank", rd_bank, 1);
        check("stall_addr", rd_addr, 0);
      end
      tick();
    end
    check("stall_nget", nget, 3);
    check("stall_t0", get_t[0], 4);
    check("stall_t1", get_t[1], 5);
    check("stall_t2", get_t[2], 17);

    // Overflow: five requests, nothing to read yet.
    num_wrd = 7; bank_full = 2'b00;
    do_reset();
    g0 = get_cnt;
    for (int c = 0; c < 30; c++) begin
      pls = (c < 5);
      if (c == 8) bank_full = 2'b01;
      if (c == 4) check("ovf_before", err_ovf, 0);
      if (c == 5) check("ovf_after", err_ovf, 1);
      tick();
    end
    check("ovf_nget", get_cnt - g0, 4);
    check("ovf_sticky", err_ovf, 1);

    // Simultaneous increment and decrement keeps reads back to back.
    num_wrd = 7; bank_full = 2'b01;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      pls = (c < 3);
      check("incdec_rden", rd_en, (c >= 2 && c <= 4));
      tick();
    end

    // Reset while reads are in flight.
    num_wrd = 3; bank_full = 2'b01;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      pls = 1'b1;
      if (c == 2) check("midrst_rden", rd_en, 1);
      tick();
    end
    rst_n = 1'b0; pls = 1'b0;
    #1;
    check_all_zero("midrst_in");
    repeat (2) tick();
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    g0 = get_cnt; rls_seen = 0;
    repeat (10) begin
      tick();
      if (bank_rls != 2'b00) rls_seen++;
    end
    check("midrst_nget", get_cnt - g0, 0);
    check("midrst_nrls", rls_seen, 0);
    pls = 1'b1;
    tick();
    pls = 1'b0;
    tick();
    check("midrst_ptr_en", rd_en, 1);
    check("midrst_ptr_bank", rd_bank, 0);
    check("midrst_ptr_addr", rd_addr, 0);
    repeat (4) tick();
    check("midrst_after_nget", get_cnt - g0, 1);

    // Randomized streaming with both banks loaded.
    for (int r = 0; r < 4; r++) begin
      num_wrd = (r == 0) ? AW'(0) : AW'($urandom_range(1, 5));
      bank_full = 2'b11;
      do_reset();
      g0 = get_cnt; nreq = 0;
      for (int c = 0; c < 60; c++) begin
        pls = 1'($urandom_range(0, 1));
        if (pls) nreq++;
        tick();
      end
      pls = 1'b0;
      repeat (12) tick();
      check("rand_nget", get_cnt - g0, nreq);
      check("rand_ovf", err_ovf, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
